// File: rtl/vx_stream_pkg.sv
// Shared types and helpers for the vx stream demux and its lane buffers.
package vx_stream_pkg;

  // Occupancy of a per-lane 2-entry elastic buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_t;

  // Width of a lane index for n lanes; never narrower than one bit.
  function automatic int sel_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/vx_demux_lane_buf.sv
// Per-lane 2-entry skid buffer: main holds the beat on the output, skid
// catches the one beat that arrives while the consumer stalls. ready is a
// flop so the consumer's ready never reaches the upstream handshake combinationally.
module vx_demux_lane_buf
  import vx_stream_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] data,
  output logic             ready,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  lane_state_t      state_q, state_d;
  logic [DATAW-1:0] main_q, main_d;
  logic [DATAW-1:0] skid_q, skid_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             pop_s;

  assign pop_s     = valid_q & ready_out;
  assign ready     = ready_q;
  assign valid_out = valid_q;
  assign data_out  = main_q;

  // Next-state, payload movement and registered handshake flags.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = data;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (push && pop_s) begin
          main_d  = data;
          state_d = ONE;
        end else if (push) begin
          skid_d  = data;
          state_d = FULL;
        end else if (pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      FULL: begin
        // No push can arrive here: ready is low while FULL.
        if (pop_s) begin
          main_d  = skid_q;
          state_d = ONE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  // Lane state and payload registers; reset empties the lane and opens ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= {DATAW{1'b0}};
      skid_q  <= {DATAW{1'b0}};
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/vx_stream_demux.sv
// Fans one valid/ready stream out to NUM_OUTPUTS lanes by a per-beat index.
// Beats with an out-of-range index are swallowed and flagged in sel_err.
module vx_stream_demux
  import vx_stream_pkg::*;
#(
  parameter  int NUM_OUTPUTS = 4,
  parameter  int DATAW       = 32,
  parameter  int BUFFERED    = 1,
  localparam int SELW        = sel_width(NUM_OUTPUTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [DATAW-1:0]             data_in,
  input  logic [SELW-1:0]              sel_in,
  output logic                         ready_in,
  output logic [NUM_OUTPUTS-1:0]       valid_out,
  output logic [NUM_OUTPUTS*DATAW-1:0] data_out,
  input  logic [NUM_OUTPUTS-1:0]       ready_out,
  output logic                         sel_err
);

  logic [NUM_OUTPUTS-1:0] lane_hit_s;
  logic [NUM_OUTPUTS-1:0] lane_ready_s;
  logic                   in_range_s;
  logic                   ready_sel_s;
  logic                   sel_err_q, sel_err_d;

  // Decode the index into a one-hot lane match; a single lane ignores sel_in.
  always_comb begin
    lane_hit_s = {NUM_OUTPUTS{1'b0}};
    if (NUM_OUTPUTS == 1) begin
      lane_hit_s = {NUM_OUTPUTS{1'b1}};
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        lane_hit_s[i] = (sel_in == SELW'(i));
      end
    end
  end

  assign in_range_s = |lane_hit_s;

  // Input ready follows the addressed lane; out-of-range beats are always taken.
  always_comb begin
    ready_sel_s = 1'b1;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (lane_hit_s[i]) begin
        ready_sel_s = lane_ready_s[i];
      end else begin
        ready_sel_s = ready_sel_s;
      end
    end
  end

  assign ready_in = ready_sel_s;

  // Sticky drop flag: set by any out-of-range beat, cleared only by reset.
  always_comb begin
    if (NUM_OUTPUTS == 1) begin
      sel_err_d = 1'b0;
    end else begin
      sel_err_d = sel_err_q | (valid_in & ~in_range_s);
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

  if (BUFFERED != 0) begin : g_buffered
    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
      logic push_s;
      assign push_s = valid_in & ready_in & lane_hit_s[i];

      vx_demux_lane_buf #(
        .DATAW (DATAW)
      ) u_lane_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .data      (data_in),
        .ready     (lane_ready_s[i]),
        .valid_out (valid_out[i]),
        .data_out  (data_out[i*DATAW +: DATAW]),
        .ready_out (ready_out[i])
      );
    end
  end else begin : g_passthru
    // Zero-latency routing: every lane sees the payload, only the addressed one is valid.
    assign lane_ready_s = ready_out;
    assign valid_out    = lane_hit_s & {NUM_OUTPUTS{valid_in}};
    assign data_out     = {NUM_OUTPUTS{data_in}};
  end

endmodule

// File: tb/tb_vx_stream_demux.sv
// Directed bench for vx_stream_demux: a buffered 4-lane instance, a buffered
// 3-lane instance for out-of-range indices, and an unbuffered 4-lane instance.
module tb_vx_stream_demux;

  logic clk = 1'b0;
  logic rst_n;

  // 4 lanes, buffered
  logic         v_in;
  logic [31:0]  d_in;
  logic [1:0]   s_in;
  logic         r_in;
  logic [3:0]   v_out;
  logic [127:0] d_out;
  logic [3:0]   r_out;
  logic         err;

  // 3 lanes, buffered
  logic         v3;
  logic [31:0]  d3;
  logic [1:0]   s3;
  logic         r_in3;
  logic [2:0]   v_out3;
  logic [95:0]  d_out3;
  logic [2:0]   r_out3;
  logic         err3;

  // 4 lanes, passthrough
  logic         v0;
  logic [31:0]  d0;
  logic [1:0]   s0;
  logic         r_in0;
  logic [3:0]   v_out0;
  logic [127:0] d_out0;
  logic [3:0]   r_out0;
  logic         err0;

  int n_cmp = 0;
  int n_bad = 0;

  // 10-unit clock.
  always #5 clk = ~clk;

  vx_stream_demux #(.NUM_OUTPUTS(4), .DATAW(32), .BUFFERED(1)) dut (
    .clk(clk), .reset(rst_n), .valid_in(v_in), .data_in(d_in), .sel_in(s_in),
    .ready_in(r_in), .valid_out(v_out), .data_out(d_out), .ready_out(r_out), .sel_err(err));

  vx_stream_demux #(.NUM_OUTPUTS(3), .DATAW(32), .BUFFERED(1)) dut3 (
    .clk(clk), .reset(rst_n), .valid_in(v3), .data_in(d3), .sel_in(s3),
    .ready_in(r_in3), .valid_out(v_out3), .data_out(d_out3), .ready_out(r_out3), .sel_err(err3));

  vx_stream_demux #(.NUM_OUTPUTS(4), .DATAW(32), .BUFFERED(0)) dut0 (
    .clk(clk), .reset(rst_n), .valid_in(v0), .data_in(d0), .sel_in(s0),
    .ready_in(r_in0), .valid_out(v_out0), .data_out(d_out0), .ready_out(r_out0), .sel_err(err0));

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (v_out !== 4'b0000) begin n_bad++; $display("FAIL reset_vout: got %b want 0000", v_out); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", r_in); end
    n_cmp++; if (v_out3 !== 3'b000) begin n_bad++; $display("FAIL reset_vout3: got %b want 000", v_out3); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_routing;
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
    r_out = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      next_cycle();
      if (t < 4) begin
        v_in = 1'b1; s_in = 2'(t); d_in = 32'hA0 + 32'(t);
      end else begin
        v_in = 1'b0;
      end
      #1;
      if (t < 4) begin
        n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL route_ready t=%0d: got %b want 1", t, r_in); end
      end
      if (t >= 1) begin
        exp_v = 4'b0001 << (t - 1);
        exp_d = 32'hA0 + 32'(t - 1);
        n_cmp++; if (v_out !== exp_v) begin n_bad++; $display("FAIL route_valid t=%0d: got %b want %b", t, v_out, exp_v); end
        n_cmp++; if (d_out[(t-1)*32 +: 32] !== exp_d) begin n_bad++; $display("FAIL route_data t=%0d: got %h want %h", t, d_out[(t-1)*32 +: 32], exp_d); end
      end
    end
    next_cycle(); #1;
    n_cmp++; if (v_out !== 4'b0000) begin n_bad++; $display("FAIL route_idle: got %b want 0000", v_out); end
  endtask

  task automatic test_backpressure;
    r_out = 4'b1101;
    next_cycle(); v_in = 1'b1; s_in = 2'd1; d_in = 32'h11; #1;
    n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL bp_acc1: got %b want 1", r_in); end
    next_cycle(); d_in = 32'h12; #1;
    n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL bp_acc2: got %b want 1", r_in); end
    n_cmp++; if (d_out[63:32] !== 32'h11) begin n_bad++; $display("FAIL bp_hold1: got %h want 11", d_out[63:32]); end
    next_cycle(); d_in = 32'h13; #1;
    n_cmp++; if (r_in !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %b want 0", r_in); end
    next_cycle(); s_in = 2'd0; d_in = 32'h50; #1;
    n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL bp_lane0_ready: got %b want 1", r_in); end
    next_cycle(); s_in = 2'd1; d_in = 32'h13; r_out = 4'b1111; #1;
    n_cmp++; if (r_in !== 1'b0) begin n_bad++; $display("FAIL bp_no_comb_path: got %b want 0", r_in); end
    n_cmp++; if (v_out !== 4'b0011) begin n_bad++; $display("FAIL bp_valid_both: got %b want 0011", v_out); end
    n_cmp++; if (d_out[31:0] !== 32'h50) begin n_bad++; $display("FAIL bp_lane0_data: got %h want 50", d_out[31:0]); end
    n_cmp++; if (d_out[63:32] !== 32'h11) begin n_bad++; $display("FAIL bp_drain1: got %h want 11", d_out[63:32]); end
    next_cycle(); #1;
    n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL bp_reopen: got %b want 1", r_in); end
    n_cmp++; if (v_out !== 4'b0010) begin n_bad++; $display("FAIL bp_valid_l1: got %b want 0010", v_out); end
    n_cmp++; if (d_out[63:32] !== 32'h12) begin n_bad++; $display("FAIL bp_drain2: got %h want 12", d_out[63:32]); end
    next_cycle(); v_in = 1'b0; #1;
    n_cmp++; if (v_out !== 4'b0010) begin n_bad++; $display("FAIL bp_valid_l1b: got %b want 0010", v_out); end
    n_cmp++; if (d_out[63:32] !== 32'h13) begin n_bad++; $display("FAIL bp_drain3: got %h want 13", d_out[63:32]); end
    next_cycle(); #1;
    n_cmp++; if (v_out !== 4'b0000) begin n_bad++; $display("FAIL bp_empty: got %b want 0000", v_out); end
  endtask

  task automatic test_push_pop;
    r_out = 4'b1111;
    next_cycle(); v_in = 1'b1; s_in = 2'd3; d_in = 32'h30; #1;
    next_cycle(); d_in = 32'h31; #1;
    n_cmp++; if (v_out !== 4'b1000) begin n_bad++; $display("FAIL pp_valid0: got %b want 1000", v_out); end
    n_cmp++; if (d_out[127:96] !== 32'h30) begin n_bad++; $display("FAIL pp_data0: got %h want 30", d_out[127:96]); end
    next_cycle(); d_in = 32'h32; #1;
    n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL pp_ready: got %b want 1", r_in); end
    n_cmp++; if (d_out[127:96] !== 32'h31) begin n_bad++; $display("FAIL pp_data1: got %h want 31", d_out[127:96]); end
    next_cycle(); v_in = 1'b0; #1;
    n_cmp++; if (v_out !== 4'b1000) begin n_bad++; $display("FAIL pp_valid2: got %b want 1000", v_out); end
    n_cmp++; if (d_out[127:96] !== 32'h32) begin n_bad++; $display("FAIL pp_data2: got %h want 32", d_out[127:96]); end
    next_cycle(); #1;
    n_cmp++; if (v_out !== 4'b0000) begin n_bad++; $display("FAIL pp_empty: got %b want 0000", v_out); end
  endtask

  task automatic test_out_of_range;
    r_out3 = 3'b111;
    next_cycle(); v3 = 1'b1; s3 = 2'd3; d3 = 32'hDEAD; #1;
    n_cmp++; if (r_in3 !== 1'b1) begin n_bad++; $display("FAIL oor_ready: got %b want 1", r_in3); end
    n_cmp++; if (err3 !== 1'b0) begin n_bad++; $display("FAIL oor_err_early: got %b want 0", err3); end
    next_cycle(); v3 = 1'b0; #1;
    n_cmp++; if (err3 !== 1'b1) begin n_bad++; $display("FAIL oor_err_set: got %b want 1", err3); end
    n_cmp++; if (v_out3 !== 3'b000) begin n_bad++; $display("FAIL oor_no_valid: got %b want 000", v_out3); end
    next_cycle(); v3 = 1'b1; s3 = 2'd2; d3 = 32'hBEEF; #1;
    n_cmp++; if (err3 !== 1'b1) begin n_bad++; $display("FAIL oor_err_sticky: got %b want 1", err3); end
    next_cycle(); v3 = 1'b0; #1;
    n_cmp++; if (v_out3 !== 3'b100) begin n_bad++; $display("FAIL oor_lane2_valid: got %b want 100", v_out3); end
    n_cmp++; if (d_out3[95:64] !== 32'hBEEF) begin n_bad++; $display("FAIL oor_lane2_data: got %h want beef", d_out3[95:64]); end
    next_cycle(); #1;
  endtask

  task automatic test_reset_mid;
    r_out = 4'b1011;
    next_cycle(); v_in = 1'b1; s_in = 2'd2; d_in = 32'h21; #1;
    next_cycle(); d_in = 32'h22; #1;
    next_cycle(); v_in = 1'b0; #1;
    n_cmp++; if (r_in !== 1'b0) begin n_bad++; $display("FAIL rst_lane2_full: got %b want 0", r_in); end
    n_cmp++; if (v_out !== 4'b0100) begin n_bad++; $display("FAIL rst_pre_valid: got %b want 0100", v_out); end
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (v_out !== 4'b0000) begin n_bad++; $display("FAIL rst_async_vout: got %b want 0000", v_out); end
    n_cmp++; if (err3 !== 1'b0) begin n_bad++; $display("FAIL rst_async_err3: got %b want 0", err3); end
    n_cmp++; if (d_out[95:64] !== 32'h0) begin n_bad++; $display("FAIL rst_data_clr: got %h want 0", d_out[95:64]); end
    n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL rst_ready_in_reset: got %b want 1", r_in); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (v_out !== 4'b0000) begin n_bad++; $display("FAIL rst_hold_vout: got %b want 0000", v_out); end
    @(negedge clk);
    rst_n = 1'b1;
    r_out = 4'b1111;
    next_cycle(); #1;
    n_cmp++; if (r_in !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", r_in); end
    n_cmp++; if (v_out !== 4'b0000) begin n_bad++; $display("FAIL rst_release_vout: got %b want 0000", v_out); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_release_err: got %b want 0", err); end
  endtask

  task automatic test_unbuffered;
    next_cycle();
    v0 = 1'b1; s0 = 2'd2; d0 = 32'h77; r_out0 = 4'b0100; #1;
    n_cmp++; if (r_in0 !== 1'b1) begin n_bad++; $display("FAIL ub_ready_hi: got %b want 1", r_in0); end
    n_cmp++; if (v_out0 !== 4'b0100) begin n_bad++; $display("FAIL ub_valid: got %b want 0100", v_out0); end
    n_cmp++; if (d_out0[95:64] !== 32'h77) begin n_bad++; $display("FAIL ub_data: got %h want 77", d_out0[95:64]); end
    r_out0 = 4'b0000; #1;
    n_cmp++; if (r_in0 !== 1'b0) begin n_bad++; $display("FAIL ub_ready_lo: got %b want 0", r_in0); end
    n_cmp++; if (v_out0 !== 4'b0100) begin n_bad++; $display("FAIL ub_valid_held: got %b want 0100", v_out0); end
    r_out0 = 4'b0100; d0 = 32'h78; #1;
    n_cmp++; if (r_in0 !== 1'b1) begin n_bad++; $display("FAIL ub_ready_hi2: got %b want 1", r_in0); end
    n_cmp++; if (d_out0[95:64] !== 32'h78) begin n_bad++; $display("FAIL ub_data2: got %h want 78", d_out0[95:64]); end
    s0 = 2'd1; r_out0 = 4'b0010; #1;
    n_cmp++; if (v_out0 !== 4'b0010) begin n_bad++; $display("FAIL ub_valid_l1: got %b want 0010", v_out0); end
    v0 = 1'b0; #1;
    n_cmp++; if (v_out0 !== 4'b0000) begin n_bad++; $display("FAIL ub_idle: got %b want 0000", v_out0); end
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL ub_err: got %b want 0", err0); end
  endtask

  // Test sequence.
  initial begin
    rst_n = 1'b0;
    v_in = 1'b0; d_in = 32'h0; s_in = 2'd0; r_out = 4'b0000;
    v3 = 1'b0; d3 = 32'h0; s3 = 2'd0; r_out3 = 3'b000;
    v0 = 1'b0; d0 = 32'h0; s0 = 2'd0; r_out0 = 4'b0000;
    test_reset();
    test_routing();
    test_backpressure();
    test_push_pop();
    test_out_of_range();
    test_reset_mid();
    test_unbuffered();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_stream_demux.md
Name: vx_stream_demux

Overview:
Routes one valid/ready stream to one of NUM_OUTPUTS lanes, chosen by an index that travels with each beat. It sits directly downstream of the request arbiter on the response/return path and fans merged traffic back out to per-requester consumers. Each lane has an optional 2-entry elastic buffer, so a stalled lane never blocks the others once its beat has been accepted. Beats carrying an out-of-range index are dropped, and this sets a sticky error flag.

Parameters:
NUM_OUTPUTS, 4, number of output lanes (>=1; non-power-of-2 allowed)
DATAW, 32, payload width in bits
BUFFERED, 1, 0 = combinational passthrough per lane; 1 = 2-entry skid buffer per lane
SELW, max(1,$clog2(NUM_OUTPUTS)), width of the lane index (localparam, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-low reset (asserted when 0), deassertion synchronous to clk
valid_in  in  1  input beat valid
data_in  in  DATAW  input payload
sel_in  in  SELW  destination lane index, qualified by valid_in
ready_in  out  1  input beat accepted this cycle when valid_in && ready_in
valid_out  out  NUM_OUTPUTS  per-lane valid
data_out  out  NUM_OUTPUTS*DATAW  per-lane payload, lane i at [i*DATAW +: DATAW]
ready_out  in  NUM_OUTPUTS  per-lane consumer ready
sel_err  out  1  sticky: an out-of-range sel_in beat was dropped

Behaviour:
- Reset (reset==0, async): all lane states go to EMPTY, valid_out=0, sel_err=0, data registers cleared to 0. ready_in is 1 while in reset when BUFFERED=1.
- Input handshake: ready_in = lane_ready[sel_in] when sel_in < NUM_OUTPUTS, else 1. ready_in never depends on valid_in.
- Out-of-range index: valid_in && sel_in >= NUM_OUTPUTS is accepted and discarded. No lane sees it. sel_err is set next cycle and stays set until reset.
- NUM_OUTPUTS==1: sel_in is ignored (always lane 0). sel_err is tied 0.
- BUFFERED=0: valid_out[i] = valid_in && sel_in==i; data_out[i] = data_in; lane_ready[i] = ready_out[i]. Zero latency, no state apart from sel_err.
- BUFFERED=1: each lane is a FSM over two registers, main and skid. lane_ready[i] = (state != FULL) and is registered, so there is no comb path from ready_out to ready_in. valid_out[i] = (state != EMPTY); data_out[i] = main.
  - EMPTY: push -> main<=data, go to ONE.
  - ONE, push and pop: main<=data, stay in ONE.
  - ONE, push only: skid<=data, go to FULL.
  - ONE, pop only: go to EMPTY.
  - FULL, pop: main<=skid, go to ONE. Push is impossible here because lane_ready=0.
  - push = valid_in && ready_in && sel_in==i; pop = valid_out[i] && ready_out[i].
- Latency with BUFFERED=1 is 1 cycle from input accept to valid_out. Throughput is 1 beat/cycle per lane when the consumer is always ready.
- Ordering: beats to the same lane leave in acceptance order. There is no ordering guarantee across lanes.
- valid_out[i] is held with data_out[i] stable until ready_out[i]; it never drops without a pop.
- Reset asserted mid-transfer discards all buffered beats with no output pulse.

Decomposition:
- Shared package vx_stream_pkg holds lane_state_t (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and a sel_width function, max(1,$clog2(n)).
- One sub-module, vx_demux_lane_buf: the per-lane 2-entry buffer. Its ports are clk, reset, push, data, ready, valid_out, data_out, ready_out, and the top generate-instantiates it NUM_OUTPUTS times when BUFFERED=1.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-traffic with lane 2 FULL. Required: valid_out=4'b0000 and sel_err=0 immediately (async); after release ready_in=1.
- Routing, BUFFERED=1, all ready_out=1: send data 0xA0..0xA3 with sel 0,1,2,3 on consecutive cycles. Required: each lane i shows 0xA0+i exactly one cycle after its accept, one beat per cycle, no stalls.
- Backpressure: ready_out[1]=0, send 3 beats (0x11,0x12,0x13) to lane 1. Required: first two accepted; ready_in=0 on the third; then raise ready_out[1]. Required: 0x11, 0x12, 0x13 drain in order, and lane 0 traffic interleaved meanwhile is unaffected.
- Simultaneous push/pop: lane 3 in ONE with ready_out[3]=1 and a push arriving. Required: it stays in ONE and the new data appears the next cycle with no bubble.
- Out-of-range, NUM_OUTPUTS=3: valid_in=1, sel_in=2'd3, data 0xDEAD. Required: ready_in=1, no valid_out asserted, sel_err=1 from the next cycle onward until reset.
- BUFFERED=0: ready_out[2] toggling. Required: ready_in follows ready_out[2] combinationally for sel_in=2, and data_out[2]==data_in in the same cycle.
